// File: rtl/mult_acc_stage_pkg.sv
// Shared defaults and state encoding for the product accumulator stage.
package mult_acc_stage_pkg;
    localparam int LAT_DEF   = 2;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } acc_state_e;
endpackage

// File: rtl/mult_acc_stage_if.sv
// Operand-qualifier and result handshake bundle between source, mult_acc_stage and consumer.
interface mult_acc_stage_if
    import mult_acc_stage_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             op_valid;
    logic             op_last;
    logic             op_ready;
    logic [31:0]      p_in;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_sum;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;

    modport master (
        output op_valid, op_last, p_in, res_ready,
        input  op_ready, res_valid, res_sum, res_count, res_ovf
    );

    modport slave (
        input  op_valid, op_last, p_in, res_ready,
        output op_ready, res_valid, res_sum, res_count, res_ovf
    );
endinterface

// File: rtl/mult_valid_delay.sv
// LAT-stage {valid,last} shift register that tracks operands through mult_top.
module mult_valid_delay
    import mult_acc_stage_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_v,
    input  logic in_l,
    output logic out_v,
    output logic out_l,
    output logic any_last
);
    logic [LAT-1:0] v_q;
    logic [LAT-1:0] l_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            l_q <= '0;
        end else begin
            v_q[0] <= in_v;
            l_q[0] <= in_l;
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                l_q[i] <= l_q[i-1];
            end
        end
    end

    assign out_v    = v_q[LAT-1];
    assign out_l    = l_q[LAT-1];
    assign any_last = |(v_q & l_q);
endmodule

// File: rtl/mult_acc_stage.sv
// Accumulates mult_top products into a saturated dot-product result held in a one-entry buffer.
//
// state | meaning
// IDLE  | no partial vector, delay line empty
// ACCUM | partial vector accumulated or products in flight
// DRAIN | vector end in the delay line, operands blocked
// HOLD  | result buffered, waiting for consumer
module mult_acc_stage
    import mult_acc_stage_pkg::*;
#(
    parameter int LAT   = LAT_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_acc_stage_if.slave  bus
);
    acc_state_e       state_q, state_d;
    logic             op_ready;
    logic             accept;
    logic             land_v, land_l, land_last;
    logic             any_last;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    logic             res_valid_q;
    logic [ACC_W-1:0] res_sum_q;
    logic [CNT_W-1:0] res_count_q;
    logic             res_ovf_q;

    // Only one unreported vector end may exist between acceptance and handshake.
    assign op_ready  = ((state_q == IDLE) || (state_q == ACCUM)) && !any_last && !res_valid_q;
    assign accept    = bus.op_valid && op_ready;
    assign land_last = land_v && land_l;

    mult_valid_delay #(.LAT(LAT)) u_valid_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_v     (accept),
        .in_l     (accept && bus.op_last),
        .out_v    (land_v),
        .out_l    (land_l),
        .any_last (any_last)
    );

    assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, bus.p_in};
    assign carry    = sum_wide[ACC_W];
    assign sum_next = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign ovf_next = ovf_q | carry;
    assign cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bus.op_last ? DRAIN : ACCUM;
            ACCUM:   if (accept && bus.op_last) state_d = DRAIN;
            DRAIN:   if (land_last) state_d = HOLD;
            HOLD:    if (res_valid_q && bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            if (land_v) begin
                if (land_l) begin
                    res_valid_q <= 1'b1;
                    res_sum_q   <= sum_next;
                    res_count_q <= cnt_next;
                    res_ovf_q   <= ovf_next;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                end else begin
                    acc_q <= sum_next;
                    cnt_q <= cnt_next;
                    ovf_q <= ovf_next;
                end
            end
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_count = res_count_q;
    assign bus.res_ovf   = res_ovf_q;
endmodule

// File: tb/tb_mult_acc_stage.sv
// Scoreboard bench: two accumulator widths driven by the same operand/product stream.
module tb_mult_acc_stage;
    import mult_acc_stage_pkg::*;

    localparam int CLK_P = 10;
    localparam int AW_A  = 40;
    localparam int AW_B  = 33;
    localparam int CW    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #(CLK_P / 2) clk = ~clk;

    mult_acc_stage_if #(.ACC_W(AW_A), .CNT_W(CW)) if_a ();
    mult_acc_stage_if #(.ACC_W(AW_B), .CNT_W(CW)) if_b ();

    mult_acc_stage #(.LAT(LAT_DEF), .ACC_W(AW_A), .CNT_W(CW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    mult_acc_stage #(.LAT(LAT_DEF), .ACC_W(AW_B), .CNT_W(CW)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    logic        op_valid  = 1'b0;
    logic        op_last   = 1'b0;
    logic        res_ready = 1'b0;
    logic [31:0] prod_now  = 32'd0;
    logic [31:0] p_pipe [LAT_DEF];

    assign if_a.op_valid  = op_valid;
    assign if_a.op_last   = op_last;
    assign if_a.res_ready = res_ready;
    assign if_a.p_in      = p_pipe[LAT_DEF-1];
    assign if_b.op_valid  = op_valid;
    assign if_b.op_last   = op_last;
    assign if_b.res_ready = res_ready;
    assign if_b.p_in      = p_pipe[LAT_DEF-1];

    // Stand-in for mult_top: the product of a pair shows up LAT cycles after it is presented.
    always @(posedge clk) begin
        p_pipe[0] <= prod_now;
        for (int i = 1; i < LAT_DEF; i++) p_pipe[i] <= p_pipe[i-1];
    end

    typedef struct {
        logic [63:0] sum_a;
        logic [63:0] ovf_a;
        logic [63:0] sum_b;
        logic [63:0] ovf_b;
        logic [63:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    bit          holding      = 1'b0;
    bit          last_open    = 1'b0;
    int          last_acc_cyc = 0;
    int          cyc          = 0;
    int          checks       = 0;
    int          errors       = 0;
    int          stall_cnt    = 0;
    logic [63:0] tot          = 64'd0;
    int          n            = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [63:0] max_of(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat(input logic [63:0] v, input int w);
        return (v > max_of(w)) ? max_of(w) : v;
    endfunction

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            op_valid = 1'b0;
            op_last  = 1'b0;
            prod_now = $urandom;
        end
    endtask

    // Waits for the source to be allowed to send, poking illegal op_valid in the meantime.
    task automatic send_pair(input logic [31:0] prod, input bit last);
        exp_t e;
        int   w = 0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_last  = 1'b0;
        prod_now = $urandom;
        while (last_open) begin
            if ($urandom_range(0, 3) == 0) begin
                op_valid = 1'b1;
                op_last  = 1'($urandom_range(0, 1));
            end
            w++;
            if (w > 300) begin
                errors++;
                $display("FAIL op_ready_wait: got no handshake after %0d cycles, required one", w);
                finish_now();
            end
            @(posedge clk); #1;
            op_valid = 1'b0;
            op_last  = 1'b0;
            prod_now = $urandom;
        end
        op_valid = 1'b1;
        op_last  = last;
        prod_now = prod;
        tot += {32'd0, prod};
        n++;
        if (last) begin
            e.sum_a = sat(tot, AW_A);
            e.ovf_a = {63'd0, tot > max_of(AW_A)};
            e.sum_b = sat(tot, AW_B);
            e.ovf_b = {63'd0, tot > max_of(AW_B)};
            e.cnt   = (n > 65535) ? 64'd65535 : 64'(n);
            e.cyc   = cyc + LAT_DEF + 1;
            q.push_back(e);
            last_open    = 1'b1;
            last_acc_cyc = cyc;
            tot = 64'd0;
            n   = 0;
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        while (last_open || q.size() != 0) begin
            idle(1);
            w++;
            if (w > 500) begin
                errors++;
                $display("FAIL drain_wait: got %0d results pending, required 0", q.size());
                finish_now();
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_op_ready_a"},  64'(if_a.op_ready),  64'd1);
        chk({tag, "_op_ready_b"},  64'(if_b.op_ready),  64'd1);
        chk({tag, "_res_valid_a"}, 64'(if_a.res_valid), 64'd0);
        chk({tag, "_res_valid_b"}, 64'(if_b.res_valid), 64'd0);
        chk({tag, "_res_sum_a"},   64'(if_a.res_sum),   64'd0);
        chk({tag, "_res_sum_b"},   64'(if_b.res_sum),   64'd0);
        chk({tag, "_res_count_a"}, 64'(if_a.res_count), 64'd0);
        chk({tag, "_res_ovf_a"},   64'(if_a.res_ovf),   64'd0);
        chk({tag, "_res_ovf_b"},   64'(if_b.res_ovf),   64'd0);
    endtask

    // Consumer: random readiness, with forced stalls for backpressure.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_cnt > 0) begin
                res_ready = 1'b0;
                stall_cnt--;
            end else begin
                res_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: expected result timing, handshake, hold-after-handshake and op_ready.
    initial begin
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 1'b0;
                cur     = '{default: 0};
            end else begin
                chk("op_ready_a", 64'(if_a.op_ready), 64'(!(last_open && last_acc_cyc < cyc)));
                chk("op_ready_b", 64'(if_b.op_ready), 64'(!(last_open && last_acc_cyc < cyc)));
                if (!holding && q.size() != 0 && q[0].cyc <= cyc) begin
                    cur     = q.pop_front();
                    holding = 1'b1;
                end
                chk("res_valid_a", 64'(if_a.res_valid), 64'(holding));
                chk("res_valid_b", 64'(if_b.res_valid), 64'(holding));
                chk("res_sum_a",   64'(if_a.res_sum),   cur.sum_a);
                chk("res_sum_b",   64'(if_b.res_sum),   cur.sum_b);
                chk("res_ovf_a",   64'(if_a.res_ovf),   cur.ovf_a);
                chk("res_ovf_b",   64'(if_b.res_ovf),   cur.ovf_b);
                chk("res_count_a", 64'(if_a.res_count), cur.cnt);
                chk("res_count_b", 64'(if_b.res_count), cur.cnt);
                if (holding && res_ready) begin
                    holding   = 1'b0;
                    last_open = 1'b0;
                end
            end
        end
    end

    initial begin
        #(CLK_P * 60000);
        errors++;
        $display("FAIL watchdog: got no end of run, required one within the time limit");
        finish_now();
    end

    initial begin
        logic [31:0] prod;
        int          len;

        #1 rst_n = 1'b0;
        #3 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        send_pair(32'd15, 1'b0);
        send_pair(32'd77, 1'b0);
        send_pair(32'd4,  1'b1);

        send_pair(32'hFFFF_FFFF, 1'b1);
        send_pair(32'd1,         1'b1);

        send_pair(32'hFFFF_FFFF, 1'b0);
        send_pair(32'hFFFF_FFFF, 1'b0);
        send_pair(32'hFFFF_FFFF, 1'b1);
        send_pair(32'd5,         1'b1);

        send_pair(32'd1000, 1'b0);
        send_pair(32'd2000, 1'b1);
        stall_cnt = 14;
        wait_drain();

        send_pair($urandom, 1'b0);
        send_pair($urandom, 1'b0);
        @(posedge clk); #1;
        op_valid  = 1'b0;
        op_last   = 1'b0;
        rst_n     = 1'b0;
        tot       = 64'd0;
        n         = 0;
        last_open = 1'b0;
        q.delete();
        #1 check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_pair(32'd9, 1'b1);

        for (int v = 0; v < 60; v++) begin
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                case ($urandom_range(0, 3))
                    0:       prod = 32'hFFFF_FFFF;
                    1:       prod = 32'($urandom_range(0, 255));
                    default: prod = $urandom;
                endcase
                send_pair(prod, k == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if (v == 30) stall_cnt = 12;
        end

        wait_drain();
        idle(5);
        chk("queue_empty", 64'(q.size()), 64'd0);
        finish_now();
    end
endmodule

// File: doc/mult_acc_stage.md
Name: mult_acc_stage

Overview:
- Sits directly downstream of mult_top and accumulates its 32-bit products into a dot-product result.
- The operand source presents x/y to mult_top and, in the same cycle, presents op_valid/op_last to this block.
- An internal LAT-deep valid/last delay line aligns these qualifiers with p_in, since mult_top has no valid of its own.
- Completed sums are held in a one-entry output buffer with a valid/ready handshake; op_ready throttles the operand source.

Parameters:
- LAT, 2, cycles from x/y presented at mult_top to the matching product on p_in (mult_top input reg + output reg).
- ACC_W, 40, accumulator/result width; must be >= 32.
- CNT_W, 16, width of the product counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  operand pair is being driven into mult_top this cycle.
- op_last  input  1  qualifies op_valid: final pair of the current vector.
- op_ready  output  1  block can absorb a new pair; the source only asserts op_valid when op_ready=1.
- p_in  input  32  product from mult_top p_out, unsigned.
- res_valid  output  1  output buffer holds a completed result.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  ACC_W  saturated sum of the vector's products.
- res_count  output  CNT_W  number of products in the vector, saturating.
- res_ovf  output  1  the sum saturated during this vector.

Behaviour:
- Reset (async assert, sync-released by the system): delay line cleared, acc=0, cnt=0, ovf=0, buffer empty.
  - Outputs: res_valid=0, res_sum=0, res_count=0, res_ovf=0, op_ready=1.
  - In-flight products are discarded. Contents of mult_top's unreset registers are never used because their valid bits are cleared.
- Accept: a pair is accepted when op_valid=1 and op_ready=1; accepted {1,op_last} enters delay stage 0.
  - op_valid while op_ready=0 is a protocol error; it is ignored and not entered.
- Delay line: LAT stages of {v,l}. Stage LAT-1 qualifies p_in in the same cycle.
- op_ready = !buf_full && !(any delay stage has v&l). At most one unreported vector end is therefore ever in flight.
- Accumulate, when stage LAT-1 has v=1:
  - sum_next = acc + zero-extend(p_in). If the carry out of ACC_W is set, sum_next = all-ones and ovf_next = 1; otherwise ovf_next = ovf.
  - cnt_next = cnt+1, saturating at all-ones.
  - If l=0: acc<=sum_next, cnt<=cnt_next, ovf<=ovf_next.
  - If l=1: the buffer loads res_sum=sum_next, res_count=cnt_next, res_ovf=ovf_next, and res_valid<=1. acc, cnt and ovf clear to 0 in the same cycle.
- Latency: op_last accepted at cycle T gives res_valid=1 at T+LAT+1, i.e. from the edge ending cycle T+LAT.
- States:
  - IDLE: cnt=0, no v in the delay line.
  - ACCUM: cnt>0 or v in flight.
  - DRAIN: a last is in flight; op_ready=0.
  - HOLD: buf_full; op_ready=0.
  - Transitions:
    - IDLE to ACCUM on accept.
    - Accept with op_last goes to DRAIN.
    - DRAIN to HOLD when the last lands.
    - HOLD to IDLE on res_valid & res_ready.
- Output handshake: the buffer is stable while res_valid=1 and res_ready=0. The handshake clears res_valid on the next edge.
  - res_sum, res_count and res_ovf hold their last value after the handshake.
- Simultaneous handshake and landing cannot occur, because op_ready blocks a new last while buf_full.
- Single-element vector (op_valid & op_last on the first pair): res_sum = p_in, res_count=1.
- Non-last products after a last cannot occur, because op_ready=0 from accepting the last until the handshake.
- Reset mid-vector or mid-HOLD: the result is lost and returns to reset values with no partial output.

Decomposition:
- Shared package: LAT default, ACC_W/CNT_W defaults, state enum {IDLE, ACCUM, DRAIN, HOLD}.
- One natural sub-module: mult_valid_delay, a LAT-stage {v,l} shift register with async active-low reset and an any_last output.
- Accumulator, saturation and output buffer stay in mult_acc_stage.

Test Plan:
- Three-element vector: accept at T, T+1, T+2 with last on the third; p_in=15, 77, 4 at T+2, T+3, T+4.
  - res_valid rises at T+5 with res_sum=96, res_count=3, res_ovf=0.
  - op_ready=0 from T+3 until the handshake.
- Single last-only pair, p_in=0xFFFFFFFF: res_sum=0x00FFFFFFFF, res_count=1; back-to-back second vector p_in=1 gives res_sum=1, proving the clear.
- Backpressure: hold res_ready=0 for 10 cycles.
  - res_* stay stable and op_ready=0 throughout.
  - One cycle after res_ready=1, res_valid=0 and op_ready=1.
- Saturation with ACC_W=33: vector of three p_in=0xFFFFFFFF gives res_sum=0x1FFFFFFFF, res_ovf=1; the next vector of p_in=5 gives res_ovf=0.
- Reset mid-vector: accept two pairs, drop rst_n for one cycle mid-flight.
  - All outputs are 0 immediately.
  - A fresh vector p_in=9 (last) gives res_sum=9, res_count=1.
- Illegal op_valid while op_ready=0 during HOLD is ignored: res_count of the next vector excludes it.
